// File: rtl/square_game_pkg.sv
// square_game_pkg: shared screen/box constants, LFSR seed and taps, the
// physics FSM state type and a box-overlap helper for the square game.
package square_game_pkg;

    localparam int unsigned SCREEN_W        = 640;
    localparam int unsigned SCREEN_H        = 480;
    localparam int unsigned PLAYER_HALF_DEF = 25;
    localparam int unsigned TARGET_HALF_DEF = 30;
    localparam int unsigned DEADZONE_DEF    = 16;
    localparam int unsigned SHIFT_DEF       = 6;
    localparam int unsigned VMAX_DEF        = 8;
    localparam int unsigned MAX_TRIES_DEF   = 16;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned LFSR_W  = 16;

    // Power-on player and target centres.
    localparam int unsigned PLAYER_X0 = 320;
    localparam int unsigned PLAYER_Y0 = 240;
    localparam int unsigned TARGET_X0 = 480;
    localparam int unsigned TARGET_Y0 = 120;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        VEL,
        POS,
        HIT,
        RELOC,
        COMMIT
    } phys_state_e;

    // True when two centres are closer than reach on both axes.
    function automatic logic boxes_overlap(input coord_t ax, input coord_t ay,
                                           input coord_t bx, input coord_t by,
                                           input coord_t reach);
        logic signed [COORD_W:0] dx;
        logic signed [COORD_W:0] dy;
        logic signed [COORD_W:0] r;
        dx = (COORD_W+1)'(ax) - (COORD_W+1)'(bx);
        dy = (COORD_W+1)'(ay) - (COORD_W+1)'(by);
        r  = (COORD_W+1)'(reach);
        if (dx < 13'sd0) dx = -dx;
        if (dy < 13'sd0) dy = -dy;
        return (dx < r) && (dy < r);
    endfunction

endpackage

// File: rtl/target_lfsr.sv
// target_lfsr: 16-bit Fibonacci LFSR used to draw target relocation candidates.
//   clk, rst   : clock, asynchronous active-high reset (loads LFSR_SEED)
//   advance    : step the register this cycle
//   value      : current LFSR contents (never all-zero)
module target_lfsr
    import square_game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/game_physics.sv
// game_physics: once-per-frame player integrator, hit detector and target
// relocator feeding the VGA controller.
//   clk_25mHz, reset      : clock, asynchronous active-high reset
//   screenEnd             : frame-boundary level; its rising edge starts an update
//   accel_valid           : strobe qualifying accel_raw_x / accel_raw_y
//   accel_raw_x/_y        : signed 12-bit raw accelerometer samples
//   accel_x/_y            : player centre (zero-extended), updated in COMMIT
//   target_x/_y           : target centre (zero-extended), updated in COMMIT
//   score                 : saturating hit counter
//   hit                   : one-cycle pulse per detected hit
module game_physics
    import square_game_pkg::*;
#(
    parameter int unsigned WIDTH       = SCREEN_W,
    parameter int unsigned HEIGHT      = SCREEN_H,
    parameter int unsigned PLAYER_HALF = PLAYER_HALF_DEF,
    parameter int unsigned TARGET_HALF = TARGET_HALF_DEF,
    parameter int unsigned DEADZONE    = DEADZONE_DEF,
    parameter int unsigned SHIFT       = SHIFT_DEF,
    parameter int unsigned VMAX        = VMAX_DEF,
    parameter int unsigned MAX_TRIES   = MAX_TRIES_DEF
)(
    input  logic                clk_25mHz,
    input  logic                reset,
    input  logic                screenEnd,
    input  logic                accel_valid,
    input  logic [COORD_W-1:0]  accel_raw_x,
    input  logic [COORD_W-1:0]  accel_raw_y,
    output logic [31:0]         accel_x,
    output logic [31:0]         accel_y,
    output logic [31:0]         target_x,
    output logic [31:0]         target_y,
    output logic [15:0]         score,
    output logic                hit
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    localparam coord_t P_X_LO = COORD_W'(PLAYER_HALF);
    localparam coord_t P_X_HI = COORD_W'(WIDTH - 1 - PLAYER_HALF);
    localparam coord_t P_Y_LO = COORD_W'(PLAYER_HALF);
    localparam coord_t P_Y_HI = COORD_W'(HEIGHT - 1 - PLAYER_HALF);
    localparam coord_t T_X_LO = COORD_W'(TARGET_HALF);
    localparam coord_t T_X_HI = COORD_W'(WIDTH - 1 - TARGET_HALF);
    localparam coord_t T_Y_LO = COORD_W'(TARGET_HALF);
    localparam coord_t T_Y_HI = COORD_W'(HEIGHT - 1 - TARGET_HALF);
    localparam coord_t X_MID  = COORD_W'(WIDTH / 2);
    localparam coord_t Y_MID  = COORD_W'(HEIGHT / 2);
    localparam coord_t REACH  = COORD_W'(PLAYER_HALF + TARGET_HALF);
    localparam coord_t DZ     = COORD_W'(DEADZONE);
    localparam coord_t VLIM   = COORD_W'(VMAX);

    // Per-axis velocity update: decay inside the deadzone, else integrate and clamp.
    function automatic coord_t vel_step(input coord_t v, input coord_t a);
        coord_t nv;
        if (a >= -DZ && a <= DZ) begin
            if (v > 12'sd0)      nv = v - 12'sd1;
            else if (v < 12'sd0) nv = v + 12'sd1;
            else                 nv = v;
        end else begin
            nv = v + (a >>> SHIFT);
            if (nv > VLIM)       nv = VLIM;
            else if (nv < -VLIM) nv = -VLIM;
        end
        return nv;
    endfunction

    // Per-axis position update with wall clamp; reports whether it clamped.
    function automatic void pos_step(input coord_t p, input coord_t v,
                                     input coord_t lo, input coord_t hi,
                                     output coord_t np, output logic clamped);
        coord_t sum;
        sum     = p + v;
        np      = sum;
        clamped = 1'b0;
        if (sum < lo) begin
            np      = lo;
            clamped = 1'b1;
        end else if (sum > hi) begin
            np      = hi;
            clamped = 1'b1;
        end
    endfunction

    phys_state_e       state_q, state_d;
    logic              se_q, se_d;
    coord_t            hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    coord_t            ax_q, ax_d, ay_q, ay_d;
    coord_t            vx_q, vx_d, vy_q, vy_d;
    coord_t            px_q, px_d, py_q, py_d;
    coord_t            tx_q, tx_d, ty_q, ty_d;
    coord_t            out_px_q, out_px_d, out_py_q, out_py_d;
    coord_t            out_tx_q, out_tx_d, out_ty_q, out_ty_d;
    logic [15:0]       score_q, score_d;
    logic              hit_q, hit_d;
    logic [TRY_W-1:0]  tries_q, tries_d;

    logic [LFSR_W-1:0] lfsr_val;
    logic              tick;
    coord_t            vx_nxt, vy_nxt, px_nxt, py_nxt;
    logic              clamp_x, clamp_y;
    logic              overlap_now;
    coord_t            cand_x, cand_y, fb_x, fb_y;
    logic              cand_ok;

    target_lfsr u_lfsr (
        .clk     (clk_25mHz),
        .rst     (reset),
        .advance (1'b1),
        .value   (lfsr_val)
    );

    // Datapath candidates; the FSM below decides which ones are loaded.
    always_comb begin
        vx_nxt = vel_step(vx_q, ax_q);
        vy_nxt = vel_step(vy_q, ay_q);
        pos_step(px_q, vx_q, P_X_LO, P_X_HI, px_nxt, clamp_x);
        pos_step(py_q, vy_q, P_Y_LO, P_Y_HI, py_nxt, clamp_y);
        overlap_now = boxes_overlap(px_q, py_q, tx_q, ty_q, REACH);
        cand_x  = {2'b00, lfsr_val[9:0]};
        cand_y  = {3'b000, lfsr_val[15:7]};
        cand_ok = (cand_x >= T_X_LO) && (cand_x <= T_X_HI) &&
                  (cand_y >= T_Y_LO) && (cand_y <= T_Y_HI) &&
                  !boxes_overlap(px_q, py_q, cand_x, cand_y, REACH);
        fb_x = (px_q < X_MID) ? T_X_HI : T_X_LO;
        fb_y = (py_q < Y_MID) ? T_Y_HI : T_Y_LO;
    end

    assign tick = screenEnd & ~se_q;

    // Next-state and register updates for the per-frame update sequence.
    always_comb begin
        state_d  = state_q;
        se_d     = screenEnd;
        hold_x_d = hold_x_q;
        hold_y_d = hold_y_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        px_d     = px_q;
        py_d     = py_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        out_px_d = out_px_q;
        out_py_d = out_py_q;
        out_tx_d = out_tx_q;
        out_ty_d = out_ty_q;
        score_d  = score_q;
        hit_d    = 1'b0;
        tries_d  = tries_q;

        if (accel_valid) begin
            hold_x_d = accel_raw_x;
            hold_y_d = accel_raw_y;
        end

        unique case (state_q)
            IDLE: begin
                // Snapshot through hold_*_d so a same-cycle sample is taken.
                if (tick) begin
                    ax_d    = hold_x_d;
                    ay_d    = hold_y_d;
                    state_d = VEL;
                end
            end
            VEL: begin
                vx_d    = vx_nxt;
                vy_d    = vy_nxt;
                state_d = POS;
            end
            POS: begin
                px_d = px_nxt;
                py_d = py_nxt;
                if (clamp_x) vx_d = '0;
                if (clamp_y) vy_d = '0;
                state_d = HIT;
            end
            HIT: begin
                if (overlap_now) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                    tries_d = '0;
                    state_d = RELOC;
                end else begin
                    state_d = COMMIT;
                end
            end
            RELOC: begin
                if (tries_q == TRY_W'(MAX_TRIES)) begin
                    tx_d    = fb_x;
                    ty_d    = fb_y;
                    state_d = COMMIT;
                end else if (cand_ok) begin
                    tx_d    = cand_x;
                    ty_d    = cand_y;
                    state_d = COMMIT;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            COMMIT: begin
                out_px_d = px_q;
                out_py_d = py_q;
                out_tx_d = tx_q;
                out_ty_d = ty_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // se_q resets high so a level already high at release is not a tick.
    always_ff @(posedge clk_25mHz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            se_q     <= 1'b1;
            hold_x_q <= '0;
            hold_y_q <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            px_q     <= COORD_W'(PLAYER_X0);
            py_q     <= COORD_W'(PLAYER_Y0);
            tx_q     <= COORD_W'(TARGET_X0);
            ty_q     <= COORD_W'(TARGET_Y0);
            out_px_q <= COORD_W'(PLAYER_X0);
            out_py_q <= COORD_W'(PLAYER_Y0);
            out_tx_q <= COORD_W'(TARGET_X0);
            out_ty_q <= COORD_W'(TARGET_Y0);
            score_q  <= '0;
            hit_q    <= 1'b0;
            tries_q  <= '0;
        end else begin
            state_q  <= state_d;
            se_q     <= se_d;
            hold_x_q <= hold_x_d;
            hold_y_q <= hold_y_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            px_q     <= px_d;
            py_q     <= py_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            out_px_q <= out_px_d;
            out_py_q <= out_py_d;
            out_tx_q <= out_tx_d;
            out_ty_q <= out_ty_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
            tries_q  <= tries_d;
        end
    end

    assign accel_x  = {20'd0, out_px_q};
    assign accel_y  = {20'd0, out_py_q};
    assign target_x = {20'd0, out_tx_q};
    assign target_y = {20'd0, out_ty_q};
    assign score    = score_q;
    assign hit      = hit_q;

endmodule

// File: tb/tb_game_physics.sv
// tb_game_physics: randomized scoreboard bench for game_physics with an
// integer reference model of the per-frame physics rules.
module tb_game_physics;

    localparam int W = 640, H = 480, PH = 25, TH = 30, DZN = 16, VM = 8;
    localparam int REACH = PH + TH;

    logic        clk_25mHz;
    logic        reset;
    logic        screenEnd;
    logic        accel_valid;
    logic [11:0] accel_raw_x, accel_raw_y;
    logic [31:0] accel_x, accel_y, target_x, target_y;
    logic [15:0] score;
    logic        hit;

    game_physics dut (
        .clk_25mHz   (clk_25mHz),
        .reset       (reset),
        .screenEnd   (screenEnd),
        .accel_valid (accel_valid),
        .accel_raw_x (accel_raw_x),
        .accel_raw_y (accel_raw_y),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .target_x    (target_x),
        .target_y    (target_y),
        .score       (score),
        .hit         (hit)
    );

    initial begin
        clk_25mHz = 1'b0;
        forever #5 clk_25mHz = ~clk_25mHz;
    end

    typedef struct {
        int old_px, old_py, old_tx, old_ty, old_score;
        int exp_px, exp_py, exp_score;
        bit exp_hit;
        bit fallback;
        int fb_x, fb_y;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   frame_done;
    int   obs_tx, obs_ty;
    int   hits_seen = 0;
    bit   force_on = 0;

    // Reference model state.
    int m_vx, m_vy, m_px, m_py, m_tx, m_ty, m_score, m_hold_x, m_hold_y;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int vel_model(input int v, input int a);
        int n;
        if (iabs(a) <= DZN) return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
        n = v + (a >>> 6);
        if (n > VM)  n = VM;
        if (n < -VM) n = -VM;
        return n;
    endfunction

    function automatic bit overlaps(input int ax, input int ay, input int bx, input int by);
        return iabs(ax - bx) < REACH && iabs(ay - by) < REACH;
    endfunction

    task automatic model_reset();
        m_vx = 0; m_vy = 0; m_px = 320; m_py = 240;
        m_tx = 480; m_ty = 120; m_score = 0; m_hold_x = 0; m_hold_y = 0;
    endtask

    task automatic model_frame(input int ax, input int ay, output bit h);
        m_vx = vel_model(m_vx, ax);
        m_vy = vel_model(m_vy, ay);
        m_px += m_vx;
        m_py += m_vy;
        if (m_px < PH)              begin m_px = PH;          m_vx = 0; end
        else if (m_px > W - 1 - PH) begin m_px = W - 1 - PH;  m_vx = 0; end
        if (m_py < PH)              begin m_py = PH;          m_vy = 0; end
        else if (m_py > H - 1 - PH) begin m_py = H - 1 - PH;  m_vy = 0; end
        h = overlaps(m_px, m_py, m_tx, m_ty);
        if (h && m_score < 65535) m_score++;
    endtask

    // Predicts whether a frame with these samples would hit, without committing.
    function automatic bit predict_hit(input int ax, input int ay);
        int vx, vy, px, py;
        vx = vel_model(m_vx, ax);
        vy = vel_model(m_vy, ay);
        px = m_px + vx;
        py = m_py + vy;
        if (px < PH) px = PH; else if (px > W - 1 - PH) px = W - 1 - PH;
        if (py < PH) py = PH; else if (py > H - 1 - PH) py = H - 1 - PH;
        return overlaps(px, py, m_tx, m_ty);
    endfunction

    task automatic apply_reset();
        @(negedge clk_25mHz);
        reset = 1'b1; screenEnd = 1'b0; accel_valid = 1'b0;
        repeat (2) @(negedge clk_25mHz);
        reset = 1'b0;
        model_reset();
        @(negedge clk_25mHz);
    endtask

    // mode 0: sample strobed before the tick; 1: strobed with the tick; 2: no new sample.
    task automatic do_frame(input int rx, input int ry, input int mode,
                            input bit midv, input bit retick, input bit rst_mid);
        exp_t e;
        bit   h;
        int   mrx, mry, w;
        if (mode == 0) begin
            accel_valid = 1'b1; accel_raw_x = 12'(rx); accel_raw_y = 12'(ry);
            m_hold_x = rx; m_hold_y = ry;
            @(negedge clk_25mHz);
            accel_valid = 1'b0; accel_raw_x = 12'($urandom); accel_raw_y = 12'($urandom);
        end else if (mode == 1) begin
            m_hold_x = rx; m_hold_y = ry;
        end
        e.old_px = m_px; e.old_py = m_py; e.old_tx = m_tx; e.old_ty = m_ty;
        e.old_score = m_score;
        model_frame(m_hold_x, m_hold_y, h);
        e.exp_px = m_px; e.exp_py = m_py; e.exp_score = m_score; e.exp_hit = h;
        e.fallback = force_on;
        e.fb_x = (m_px < W / 2) ? W - 1 - TH : TH;
        e.fb_y = (m_py < H / 2) ? H - 1 - TH : TH;
        frame_done = 1'b0;
        if (!rst_mid) sb_q.push_back(e);
        screenEnd = 1'b1;
        if (mode == 1) begin
            accel_valid = 1'b1; accel_raw_x = 12'(rx); accel_raw_y = 12'(ry);
        end
        @(negedge clk_25mHz);
        accel_valid = 1'b0; accel_raw_x = 12'($urandom); accel_raw_y = 12'($urandom);
        @(negedge clk_25mHz);
        if (midv) begin
            mrx = int'($urandom_range(4095)) - 2048;
            mry = int'($urandom_range(4095)) - 2048;
            accel_valid = 1'b1; accel_raw_x = 12'(mrx); accel_raw_y = 12'(mry);
            m_hold_x = mrx; m_hold_y = mry;
        end
        @(negedge clk_25mHz);
        accel_valid = 1'b0; screenEnd = 1'b0;
        if (rst_mid) begin
            repeat (5) @(negedge clk_25mHz);
            #2 reset = 1'b1;
            #1;
            check("rst_mid_accel_x", int'(accel_x), 320);
            check("rst_mid_accel_y", int'(accel_y), 240);
            check("rst_mid_target_x", int'(target_x), 480);
            check("rst_mid_target_y", int'(target_y), 120);
            check("rst_mid_score", int'(score), 0);
            check("rst_mid_hit", int'(hit), 0);
            @(negedge clk_25mHz);
            reset = 1'b0;
            model_reset();
            repeat (2) @(negedge clk_25mHz);
            return;
        end
        if (retick && h) begin
            @(negedge clk_25mHz);
            screenEnd = 1'b1;
            @(negedge clk_25mHz);
            screenEnd = 1'b0;
        end
        for (w = 0; w < 60 && !frame_done; w++) @(negedge clk_25mHz);
        if (!frame_done) check("frame_timeout", 0, 1);
        if (h) begin
            m_tx = obs_tx;
            m_ty = obs_ty;
        end
        repeat (2) @(negedge clk_25mHz);
    endtask

    // Monitor: pops one expectation per tick and follows the update cycle by cycle.
    initial begin : monitor
        exp_t e;
        int   hits, commit_k;
        bit   changed, valid_t;
        forever begin
            wait (sb_q.size() != 0);
            e = sb_q.pop_front();
            hits = 0;
            commit_k = -1;
            @(posedge clk_25mHz);
            for (int k = 0; k <= 22; k++) begin
                @(negedge clk_25mHz);
                if (hit === 1'b1) hits++;
                changed = int'(accel_x) != e.old_px || int'(accel_y) != e.old_py ||
                          int'(target_x) != e.old_tx || int'(target_y) != e.old_ty;
                if (changed && commit_k < 0) commit_k = k;
                if (k == 2) check("score_before_hit", int'(score), e.old_score);
                if (k == 3) begin
                    check("x_held_k3", int'(accel_x), e.old_px);
                    check("y_held_k3", int'(accel_y), e.old_py);
                    check("hit_pulse_k3", int'(hit), e.exp_hit ? 1 : 0);
                    check("score_k3", int'(score), e.exp_score);
                end
                if (k == 4 && !e.exp_hit) begin
                    check("x_commit", int'(accel_x), e.exp_px);
                    check("y_commit", int'(accel_y), e.exp_py);
                    check("tx_unchanged", int'(target_x), e.old_tx);
                    check("ty_unchanged", int'(target_y), e.old_ty);
                end
            end
            check("hit_pulse_count", hits, e.exp_hit ? 1 : 0);
            check("score_final", int'(score), e.exp_score);
            if (e.exp_hit) begin
                check("hit_x_commit", int'(accel_x), e.exp_px);
                check("hit_y_commit", int'(accel_y), e.exp_py);
                check("reloc_latency_ok", int'(commit_k >= 4 && commit_k <= 21), 1);
                if (e.fallback) begin
                    check("fallback_tx", int'(target_x), e.fb_x);
                    check("fallback_ty", int'(target_y), e.fb_y);
                end else begin
                    valid_t = int'(target_x) >= TH && int'(target_x) <= W - 1 - TH &&
                              int'(target_y) >= TH && int'(target_y) <= H - 1 - TH &&
                              !overlaps(e.exp_px, e.exp_py, int'(target_x), int'(target_y));
                    check("target_valid", int'(valid_t), 1);
                end
                obs_tx = int'(target_x);
                obs_ty = int'(target_y);
                hits_seen++;
            end
            frame_done = 1'b1;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int acc_exp[4];
        int dz_step[3];
        int prev_x, n, hits_before, rx, ry, mag;
        bit ph;
        acc_exp = '{323, 329, 337, 345};
        dz_step = '{7, 6, 5};

        reset = 1'b0; screenEnd = 1'b0; accel_valid = 1'b0;
        accel_raw_x = '0; accel_raw_y = '0;
        #3 reset = 1'b1;
        #1;
        check("reset_accel_x", int'(accel_x), 320);
        check("reset_accel_y", int'(accel_y), 240);
        check("reset_target_x", int'(target_x), 480);
        check("reset_target_y", int'(target_y), 120);
        check("reset_score", int'(score), 0);
        check("reset_hit", int'(hit), 0);
        repeat (2) @(negedge clk_25mHz);
        reset = 1'b0;
        model_reset();
        @(negedge clk_25mHz);

        // Acceleration ramp.
        for (int i = 0; i < 4; i++) begin
            do_frame(200, 0, (i == 0) ? 0 : 2, 1'b0, 1'b0, 1'b0);
            check("accel_ramp_x", int'(accel_x), acc_exp[i]);
        end
        // Deadzone decay.
        for (int i = 0; i < 3; i++) begin
            prev_x = int'(accel_x);
            do_frame(10, 0, 1, 1'b0, 1'b0, 1'b0);
            check("deadzone_step", int'(accel_x) - prev_x, dz_step[i]);
        end
        // Left wall.
        for (int i = 0; i < 60; i++) do_frame(-2048, 0, (i == 0) ? 0 : 2, 1'b0, 1'b0, 1'b0);
        check("wall_x", int'(accel_x), 25);

        // Hit with every candidate rejected: fallback corner.
        apply_reset();
        force dut.lfsr_val = 16'hFFFF;
        force_on = 1'b1;
        n = 0;
        do begin
            ph = predict_hit(2047, -2048);
            do_frame(2047, -2048, (n == 0) ? 0 : 2, 1'b0, 1'b1, 1'b0);
            n++;
        end while (!ph && n < 40);
        check("fallback_hit_seen", int'(ph), 1);

        // Reset while the relocation search is still running.
        n = 0;
        ph = 1'b0;
        while (!ph && n < 100) begin
            ph = predict_hit(-2048, 2047);
            if (!ph) do_frame(-2048, 2047, 1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("reloc_reset_setup", int'(ph), 1);
        do_frame(-2048, 2047, 1, 1'b0, 1'b0, 1'b1);
        release dut.lfsr_val;
        force_on = 1'b0;

        // Randomized chase of the target.
        hits_before = hits_seen;
        for (int i = 0; i < 250; i++) begin
            mag = ($urandom_range(9) < 2) ? int'($urandom_range(20)) : int'($urandom_range(2047));
            if ($urandom_range(99) < 85) begin
                rx = (m_tx >= m_px) ? mag : -mag;
                ry = (m_ty >= m_py) ? mag : -mag;
            end else begin
                rx = int'($urandom_range(4095)) - 2048;
                ry = int'($urandom_range(4095)) - 2048;
            end
            do_frame(rx, ry, (i == 0) ? 0 : int'($urandom_range(2)),
                     ($urandom_range(3) == 0), $urandom_range(1) == 1, 1'b0);
        end
        check("random_hits_seen", int'(hits_seen > hits_before), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_physics.md
# game_physics

Per-frame game-state update stage that sits directly upstream of `VGAController`. It latches raw accelerometer samples and integrates them into a clamped player velocity and position once per frame. It detects player/target overlap, relocates the target pseudo-randomly on a hit, and keeps a saturating score. Its `accel_x`/`accel_y`/`target_x`/`target_y` outputs drive the same-named controller inputs.

## Interface
- `WIDTH`, 640: screen width in pixels.
- `HEIGHT`, 480: screen height in pixels.
- `PLAYER_HALF`, 25: player box half-size.
- `TARGET_HALF`, 30: target box half-size.
- `DEADZONE`, 16: raw magnitude treated as zero.
- `SHIFT`, 6: arithmetic right shift from raw accel to velocity delta.
- `VMAX`, 8: velocity clamp magnitude.
- `MAX_TRIES`, 16: relocation attempts before fallback.

- `clk_25mHz` in 1: the block's only clock.
- `reset` in 1: asynchronous, active-high.
- `screenEnd` in 1: frame-boundary level from `VGATimingGenerator`.
- `accel_valid` in 1: one-cycle strobe; raw samples are valid.
- `accel_raw_x`, `accel_raw_y` in 12: signed two's-complement raw samples.
- `accel_x`, `accel_y` out 32: player centre, zero-extended.
- `target_x`, `target_y` out 32: target centre, zero-extended.
- `score` out 16: hit count.
- `hit` out 1: one-cycle pulse on a detected hit.

## Operation
- **Reset values:**
  - `accel_x`=320, `accel_y`=240.
  - `target_x`=480, `target_y`=120.
  - `score`=0, `hit`=0.
  - Velocities 0.
  - LFSR = 16'hACE1.
  - FSM IDLE.
  - Registered `screenEnd` copy = 1, so a high level at reset release does not trigger an update.
- **Sample hold:** on `accel_valid`, capture both raw samples into hold registers. The latest sample wins. Capture happens in every state.
- **Frame tick:** tick = `screenEnd` & ~previous. Ticks outside IDLE are ignored.
- **FSM:** IDLE → VEL → POS → HIT → (RELOC)* → COMMIT → IDLE.
- **IDLE:** on tick, snapshot the hold registers into working registers. Later `accel_valid` does not affect this frame.
- **VEL**, per axis:
  - If |a| ≤ DEADZONE: velocity decays one step toward 0.
  - Otherwise: v += (a >>> SHIFT), then clamp to [-VMAX, +VMAX].
  - Use 12-bit signed arithmetic.
- **POS**, per axis:
  - p += v, computed 12-bit signed.
  - Clamp x to [PLAYER_HALF, WIDTH-1-PLAYER_HALF] and y to [PLAYER_HALF, HEIGHT-1-PLAYER_HALF].
  - If clamping occurred on an axis, that axis's velocity becomes 0.
- **HIT:** overlap = |px−tx| < PLAYER_HALF+TARGET_HALF on both axes.
  - Overlap: pulse `hit`, score += 1 saturating at 16'hFFFF, go to RELOC.
  - Otherwise: go to COMMIT.
- **RELOC**, one candidate per cycle:
  - Candidate = (lfsr[9:0], lfsr[15:7]).
  - Accept if x is in [TARGET_HALF, WIDTH-1-TARGET_HALF], y is in [TARGET_HALF, HEIGHT-1-TARGET_HALF], and the candidate does not overlap the new player position.
  - Otherwise advance the LFSR and retry.
  - After MAX_TRIES rejections, use the fallback: tx = px<WIDTH/2 ? WIDTH-1-TARGET_HALF : TARGET_HALF, and ty likewise with HEIGHT.
- **LFSR:** Fibonacci, taps 16,14,13,11. It free-runs every cycle outside reset and is never all-zero.
- **COMMIT:** all four position outputs update together in this cycle only.

## Timing
- `hit` asserts in the cycle after HIT is entered, for exactly one cycle.
- Outputs change only in COMMIT, at most once per tick.
- Tick-to-COMMIT latency:
  - 4 cycles with no hit.
  - 5 to 5+MAX_TRIES cycles with a hit, i.e. ≤21 at defaults.
- Updated values are consumed by the controller one frame later.
- **Reset mid-update:** everything returns to reset values immediately and the in-flight frame is discarded.
- **Simultaneous `accel_valid` and tick:** the new sample is captured, and the snapshot takes the new sample.

## Structure
- Shared package `square_game_pkg` holds:
  - Screen and box constants.
  - LFSR seed and taps.
  - FSM state enum: IDLE, VEL, POS, HIT, RELOC, COMMIT.
- Sub-module `target_lfsr`: 16-bit LFSR with `advance` enable and reset seed.
- The per-axis integrator stays inline, as two instances of the same logic.

## Test plan
- **Reset:** assert `reset` asynchronously → outputs 320/240/480/120, `score`=0, `hit`=0, with no clock edge needed.
- **Acceleration:** `accel_raw_x`=200 held, 4 ticks → vx 3,6,8,8; `accel_x` 323,329,337,345, each ≤5 cycles after the tick.
- **Deadzone decay:** after vx=8, `accel_raw_x`=10 for 3 ticks → vx 7,6,5 and x advances by 7,6,5.
- **Wall clamp:** `accel_raw_x`=−2048 for many ticks → `accel_x` settles at exactly 25 and never goes below it; vx is 0 on each clamped frame.
- **Hit path:** drive the player to within 54 px of the target on both axes → single `hit` pulse, `score`=1, new target in range and non-overlapping within ≤21 cycles. With LFSR forced to always reject, the fallback corner is used.
- **Tick handling:**
  - `screenEnd` held high 3 cycles → exactly one update.
  - A second rising edge during RELOC is ignored.
  - `accel_valid` mid-update changes only the next frame.
  - `reset` asserted during RELOC → all outputs return to reset values.
